// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam logic [31:0] RESET_ADDR = 32'hBFC00000;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side handshake.
interface fetch_if #(
    parameter int Width = 32
);
    import fetch_pkg::*;

    logic             imem_req;
    logic [Width-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [Width-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [Width-1:0] instr;
    logic [Width-1:0] instr_pc;
    logic [Width-1:0] pc_plus4;
    pcsrc_t           PCsrc;
    logic [Width-1:0] ImmExt;
    logic [Width-1:0] RS1;
    logic             fetch_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, fetch_err,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, PCsrc, ImmExt, RS1
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, fetch_err,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, PCsrc, ImmExt, RS1
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO; the head entry drives the decode outputs directly.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int               Width     = 32,
    parameter logic [Width-1:0] ResetAddr = Width'(RESET_ADDR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_pc,
    input  logic [Width-1:0] push_instr,
    input  logic             pop,
    input  logic             flush,
    output logic             valid,
    output logic [Width-1:0] head_pc,
    output logic [Width-1:0] head_pc4,
    output logic [Width-1:0] head_instr,
    output logic [1:0]       occupancy
);

    logic [Width-1:0] tail_pc;
    logic [Width-1:0] tail_instr;
    logic [1:0]       count;
    logic             do_pop;
    logic             do_push;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != 2'd2) || do_pop);
    assign valid     = count != 2'd0;
    assign occupancy = count;

    // An emptied head reverts to nop so decode never sees a stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head_pc    <= ResetAddr;
            head_pc4   <= ResetAddr + Width'(4);
            head_instr <= Width'(NOP_INSTR);
            tail_pc    <= ResetAddr;
            tail_instr <= Width'(NOP_INSTR);
        end else if (flush) begin
            count      <= 2'd0;
            head_instr <= Width'(NOP_INSTR);
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= push_pc;
                        head_pc4   <= push_pc + Width'(4);
                        head_instr <= push_instr;
                    end else begin
                        tail_pc    <= push_pc;
                        tail_instr <= push_instr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_pc4   <= tail_pc + Width'(4);
                        head_instr <= tail_instr;
                    end else begin
                        head_instr <= Width'(NOP_INSTR);
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_pc4   <= tail_pc + Width'(4);
                        head_instr <= tail_instr;
                        tail_pc    <= push_pc;
                        tail_instr <= push_instr;
                    end else begin
                        head_pc    <= push_pc;
                        head_pc4   <= push_pc + Width'(4);
                        head_instr <= push_instr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, tracks in-flight fetches, applies retire-time redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               Width     = 32,
    parameter logic [Width-1:0] ResetAddr = Width'(RESET_ADDR)
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);

    fetch_state_t     state;
    logic [Width-1:0] fetch_pc;
    logic [Width-1:0] tag_pc;
    logic [1:0]       out_cnt;
    logic [1:0]       drop_cnt;
    logic             err;

    logic [1:0]       out_next;
    logic [1:0]       drop_next;
    logic [1:0]       occupancy;
    logic [2:0]       load;
    logic             buf_valid;
    logic             retire;
    logic             redirect;
    logic             misaligned;
    logic             can_fetch;
    logic             issue;
    logic             resp;
    logic             dropping;
    logic             push;
    logic [Width-1:0] target;
    logic [Width-1:0] head_pc;
    logic [Width-1:0] head_pc4;
    logic [Width-1:0] head_instr;

    function automatic logic [Width-1:0] redirect_target(
        input pcsrc_t           src,
        input logic [Width-1:0] pc,
        input logic [Width-1:0] imm,
        input logic [Width-1:0] rs1
    );
        logic [Width-1:0] sum;
        if (src == PC_JALR) begin
            sum    = rs1 + imm;
            sum[0] = 1'b0;
        end else begin
            sum = pc + imm;
        end
        return sum;
    endfunction

    assign retire     = buf_valid && bus.instr_ready;
    assign redirect   = retire && (bus.PCsrc != PC_SEQ);
    assign target     = redirect_target(bus.PCsrc, head_pc, bus.ImmExt, bus.RS1);
    assign misaligned = is_misaligned(target[1:0]);
    assign can_fetch  = (state == ST_RUN) || (state == ST_FLUSH);

    // A same-cycle pop frees a slot, which is what lets L=1 sustain one word per cycle.
    assign load      = {1'b0, occupancy} - {2'b00, retire} + {1'b0, out_cnt};
    assign issue     = bus.imem_req && bus.imem_gnt;
    assign resp      = bus.imem_rvalid;
    assign dropping  = drop_cnt != 2'd0;
    assign push      = resp && !dropping && (state != ST_HALT) && !redirect;
    assign out_next  = out_cnt + {1'b0, issue} - {1'b0, resp};
    assign drop_next = (resp && dropping) ? drop_cnt - 2'd1 : drop_cnt;

    assign bus.imem_req    = can_fetch && !redirect && (load < 3'd2);
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = buf_valid;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;
    assign bus.pc_plus4    = head_pc4;
    assign bus.fetch_err   = err;

    fetch_buffer #(
        .Width     (Width),
        .ResetAddr (ResetAddr)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_pc    (tag_pc),
        .push_instr (bus.imem_rdata),
        .pop        (retire),
        .flush      (redirect),
        .valid      (buf_valid),
        .head_pc    (head_pc),
        .head_pc4   (head_pc4),
        .head_instr (head_instr),
        .occupancy  (occupancy)
    );

    // tag_pc is the address of the oldest response that will be kept; stale ones are dropped first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            fetch_pc <= ResetAddr;
            tag_pc   <= ResetAddr;
            out_cnt  <= 2'd0;
            drop_cnt <= 2'd0;
            err      <= 1'b0;
        end else begin
            out_cnt  <= out_next;
            drop_cnt <= drop_next;
            if (issue) begin
                fetch_pc <= fetch_pc + Width'(4);
            end
            if (push) begin
                tag_pc <= tag_pc + Width'(4);
            end
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN, ST_FLUSH: begin
                    if (redirect) begin
                        if (misaligned) begin
                            err      <= 1'b1;
                            drop_cnt <= 2'd0;
                            state    <= ST_HALT;
                        end else begin
                            fetch_pc <= target;
                            tag_pc   <= target;
                            drop_cnt <= out_next;
                            state    <= (out_next != 2'd0) ? ST_FLUSH : ST_RUN;
                        end
                    end else if ((state == ST_FLUSH) && (drop_next == 2'd0)) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with configurable latency, expected-retire queue.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RA = 32'hBFC00000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.Width(32)) bus ();

    fetch_unit #(.Width(32), .ResetAddr(RA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          budget = 0;
    int          issue_cnt = 0;
    logic        trig_armed = 1'b0;
    logic        trig_fired = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [31:0] trig_imm = '0;
    logic [31:0] trig_rs1 = '0;
    pcsrc_t      trig_src = PC_SEQ;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h00005A13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{base + 32'(4 * i), mem_word(base + 32'(4 * i))});
        end
    endtask

    task automatic arm(input logic [31:0] pc, input pcsrc_t src, input logic [31:0] imm,
                       input logic [31:0] rs1);
        trig_pc    = pc;
        trig_src   = src;
        trig_imm   = imm;
        trig_rs1   = rs1;
        trig_fired = 1'b0;
        trig_armed = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        budget     = 0;
        trig_armed = 1'b0;
        trig_fired = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        issue_cnt = 0;
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_fire(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (!trig_fired && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(trig_fired), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req),    32'd0);
        chk({tag, "_addr"},  bus.imem_addr,        RA);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_instr"}, bus.instr,            32'h00000013);
        chk({tag, "_pc"},    bus.instr_pc,         RA);
        chk({tag, "_pc4"},   bus.pc_plus4,         32'hBFC00004);
        chk({tag, "_err"},   32'(bus.fetch_err),   32'd0);
    endtask

    // Instruction memory: responses in issue order, mem_lat cycles after issue.
    initial begin
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
            if (!rst_n) begin
                mem_q.delete();
            end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            @(negedge clk);
            if (rst_n && bus.imem_req && bus.imem_gnt) begin
                mem_q.push_back('{bus.imem_addr, cyc + mem_lat});
                issue_cnt++;
            end
        end
    end

    // Consumer: retires while budget remains, injecting the armed redirect at its pc.
    initial begin
        bus.instr_ready = 1'b0;
        bus.PCsrc       = PC_SEQ;
        bus.ImmExt      = '0;
        bus.RS1         = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.PCsrc       = PC_SEQ;
            bus.ImmExt      = '0;
            bus.RS1         = '0;
            bus.instr_ready = (budget > 0) && rst_n;
            if (bus.instr_ready && bus.instr_valid) begin
                budget--;
                if (trig_armed && bus.instr_pc == trig_pc) begin
                    bus.PCsrc  = trig_src;
                    bus.ImmExt = trig_imm;
                    bus.RS1    = trig_rs1;
                    trig_armed = 1'b0;
                    trig_fired = 1'b1;
                end
            end
        end
    end

    // Monitor: every retire is matched against the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected actual_pc=%h required=none", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_pc", bus.instr_pc, e.pc);
                    chk("retire_instr", bus.instr, e.word);
                    chk("retire_pc4", bus.pc_plus4, e.pc + 32'd4);
                end
            end
            if (rst_n && !bus.instr_valid) begin
                chk("idle_nop", bus.instr, 32'h00000013);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Startup with L=1 and a ready consumer.
        mem_lat = 1;
        do_reset();
        budget = 3;
        expect_seq(RA, 3);
        @(negedge clk); chk("boot_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk); chk("first_req", 32'(bus.imem_req), 32'd1);
                        chk("first_addr", bus.imem_addr, RA);
        @(negedge clk); chk("valid_c2", 32'(bus.instr_valid), 32'd0);
        @(negedge clk); chk("valid_c3", 32'(bus.instr_valid), 32'd1);
                        chk("stream_pc0", bus.instr_pc, RA);
        @(negedge clk); chk("stream_pc1", bus.instr_pc, RA + 32'd4);
        @(negedge clk); chk("stream_pc2", bus.instr_pc, RA + 32'd8);
        wait_drain("drain_startup", 20);

        // Backpressure: consumer stalled, only two fetches may be issued.
        do_reset();
        begin
            int n = 0;
            while (!bus.instr_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_pc", bus.instr_pc, RA);
        end
        chk("stall_issues", 32'(issue_cnt), 32'd2);
        budget = 4;
        expect_seq(RA, 4);
        wait_drain("drain_stall", 30);

        // Backward branch from 0xBFC00008 to 0xBFC00000.
        do_reset();
        budget = 5;
        expect_seq(RA, 3);
        expect_seq(RA, 2);
        arm(RA + 32'd8, PC_BRANCH, 32'hFFFFFFF8, 32'd0);
        wait_fire("branch_fire", 30);
        @(negedge clk);
        chk("branch_valid", 32'(bus.instr_valid), 32'd0);
        chk("branch_addr", bus.imem_addr, RA);
        wait_drain("drain_branch", 30);

        // Jalr with L=3: target (0x1001+4)&~1, stale in-flight words discarded.
        mem_lat = 3;
        do_reset();
        budget = 4;
        expect_seq(RA, 2);
        expect_seq(32'h00001004, 2);
        arm(RA + 32'd4, PC_JALR, 32'd4, 32'h00001001);
        wait_fire("jalr_fire", 40);
        @(negedge clk);
        chk("jalr_valid", 32'(bus.instr_valid), 32'd0);
        chk("jalr_addr", bus.imem_addr, 32'h00001004);
        wait_drain("drain_jalr", 60);

        // Misaligned jal halts fetch until reset.
        mem_lat = 1;
        do_reset();
        budget = 1;
        expect_seq(RA, 1);
        arm(RA, PC_JAL, 32'd2, 32'd0);
        wait_fire("jal_fire", 30);
        @(negedge clk);
        chk("halt_err", 32'(bus.fetch_err), 32'd1);
        chk("halt_valid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(bus.imem_req), 32'd0);
        end
        wait_drain("drain_halt", 5);
        #2 rst_n = 1'b0;
        #1 chk("async_err_clear", 32'(bus.fetch_err), 32'd0);

        // Reset with two fetches outstanding.
        mem_lat = 3;
        do_reset();
        repeat (4) @(negedge clk);
        chk("mid_issues", 32'(issue_cnt), 32'd2);
        chk("mid_addr", bus.imem_addr, RA + 32'd8);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        issue_cnt = 0;
        #1 rst_n = 1'b1;
        budget = 1;
        expect_seq(RA, 1);
        @(negedge clk); chk("resume_boot_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk); chk("resume_req", 32'(bus.imem_req), 32'd1);
                        chk("resume_addr", bus.imem_addr, RA);
        wait_drain("drain_resume", 30);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
